// File: rtl/dp_result_drain.sv
// Snapshot B*B accumulator results, requantize each one, and stream them out row-major.
// Latency: element (0,0) is valid the cycle after capture; B*B cycles per drain with no stalls.
// Backpressure: out_ready_i low holds the current element and its index stable; nothing skipped or repeated.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), asynchronous active-high reset
//   capture_i               snapshot request, honoured only while idle
//   results_i, shift_i      flattened signed results ((r*B+c) order) and right-shift amount
//   out_valid_o/ready_i     valid/ready handshake toward the output buffer
//   out_data_o              requantized signed element
//   out_row_o, out_col_o    index of the presented element
//   out_last_o              presented element is (B-1,B-1)
//   busy_o                  draining
//   done_o                  one-cycle pulse after the final transfer
module dp_result_drain #(
   parameter int B               = 4,
   parameter int quantized_width = 8
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 capture_i,
   input  logic [B*B*2*quantized_width-1:0]     results_i,
   input  logic [$clog2(2*quantized_width)-1:0] shift_i,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i,
   output logic [quantized_width-1:0]           out_data_o,
   output logic [$clog2(B)-1:0]                 out_row_o,
   output logic [$clog2(B)-1:0]                 out_col_o,
   output logic                                 out_last_o,
   output logic                                 busy_o,
   output logic                                 done_o
);

   localparam int IW = 2 * quantized_width;   // input element width
   localparam int SW = $clog2(IW);            // shift amount width
   localparam int RW = $clog2(B);             // row / column index width
   localparam int XW = 2 * RW;                // flat index width (B is a power of two)
   localparam int NE = B * B;

   localparam logic [XW-1:0] LAST_IDX = XW'(NE - 1);

   // Saturation bounds in the extended (IW+1)-bit domain.
   localparam logic signed [IW:0] QMAX = {{(IW - quantized_width + 2){1'b0}}, {(quantized_width - 1){1'b1}}};
   localparam logic signed [IW:0] QMIN = ~QMAX;
   localparam logic [IW:0]        ONE  = {{IW{1'b0}}, 1'b1};

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   logic [0:0]          state_q;
   logic [NE*IW-1:0]    snap_q;
   logic [SW-1:0]       shift_q;
   logic [XW-1:0]       idx_q;
   logic                done_q;
   logic                drain;

   logic signed [IW-1:0] elem;
   logic signed [IW:0]   ext;
   logic signed [IW:0]   bias;
   logic signed [IW:0]   sum;
   logic signed [IW:0]   shr;
   logic [quantized_width-1:0] q;

   assign drain = (state_q == DRAIN);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         snap_q  <= '0;
         shift_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (capture_i) begin
                  snap_q  <= results_i;
                  shift_q <= shift_i;
                  idx_q   <= '0;
                  state_q <= DRAIN;
               end
            end
            default: begin
               // capture_i is deliberately not looked at here, so a request
               // during a drain is dropped rather than queued.
               if (out_ready_i) begin
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Requantize the element selected by the registered index: round half
   // toward +inf, arithmetic shift, then saturate. The extra top bit keeps
   // the rounding add from overflowing.
   always_comb begin
      elem = snap_q[int'(idx_q)*IW +: IW];
      ext  = {elem[IW-1], elem};
      bias = (shift_q != '0) ? (ONE << (shift_q - 1'b1)) : '0;
      sum  = ext + bias;
      shr  = sum >>> shift_q;
      if (shr > QMAX) begin
         q = QMAX[quantized_width-1:0];
      end else if (shr < QMIN) begin
         q = QMIN[quantized_width-1:0];
      end else begin
         q = shr[quantized_width-1:0];
      end
   end

   assign out_valid_o = drain;
   assign busy_o      = drain;
   assign done_o      = done_q;
   assign out_data_o  = drain ? q : '0;
   // idx_q returns to zero whenever the block is idle, so row/col read 0 then.
   assign out_row_o   = idx_q[XW-1:RW];
   assign out_col_o   = idx_q[RW-1:0];
   assign out_last_o  = drain && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_dp_result_drain.sv
module tb_dp_result_drain;

   localparam int B  = 4;
   localparam int QW = 8;
   localparam int IW = 2 * QW;
   localparam int NE = B * B;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic              capture_i;
   logic [NE*IW-1:0]  results_i;
   logic [3:0]        shift_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [QW-1:0]     out_data_o;
   logic [1:0]        out_row_o;
   logic [1:0]        out_col_o;
   logic              out_last_o;
   logic              busy_o;
   logic              done_o;
   logic [15:0]       all_outs;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] row;
      logic [1:0] col;
      logic       last;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   dp_result_drain #(.B(B), .quantized_width(QW)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .capture_i   (capture_i),
      .results_i   (results_i),
      .shift_i     (shift_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_row_o   (out_row_o),
      .out_col_o   (out_col_o),
      .out_last_o  (out_last_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   assign all_outs = {out_valid_o, out_data_o, out_row_o, out_col_o, out_last_o, busy_o, done_o};

   // Reference requantizer: floor division after the rounding offset, then clamp.
   function automatic logic [7:0] model_rq(input logic signed [15:0] x, input int s);
      longint t, d, q;
      t = x;
      if (s > 0) t = t + (longint'(1) << (s - 1));
      d = longint'(1) << s;
      q = t / d;
      if ((t % d) != 0 && t < 0) q = q - 1;
      if (q > 127) q = 127;
      else if (q < -128) q = -128;
      return q[7:0];
   endfunction

   task automatic push_all(input logic [NE*IW-1:0] v, input int s);
      exp_t e;
      for (int i = 0; i < NE; i++) begin
         e.data = model_rq(v[i*IW +: IW], s);
         e.row  = 2'(i / B);
         e.col  = 2'(i % B);
         e.last = (i == NE - 1);
         sb.push_back(e);
      end
   endtask

   // Drives a capture request for one cycle (the caller's next negedge clears it).
   task automatic do_capture(input logic [NE*IW-1:0] v, input int s);
      @(negedge clk_i);
      results_i = v;
      shift_i   = 4'(s);
      capture_i = 1'b1;
   endtask

   task automatic test_reset();
      logic [NE*IW-1:0] v;
      #3;
      n_cmp++;
      if (all_outs !== '0) begin n_fail++; $display("FAIL reset_init got=%h exp=0", all_outs); end
      @(negedge clk_i); reset_i = 1'b0;
      for (int i = 0; i < NE; i++) v[i*IW +: IW] = 16'($urandom);
      do_capture(v, 2);
      @(negedge clk_i); capture_i = 1'b0;
      n_cmp++;
      if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid got=%b exp=1", out_valid_o); end
      @(negedge clk_i);
      #2 reset_i = 1'b1;
      #1;
      n_cmp++;
      if (all_outs !== '0) begin n_fail++; $display("FAIL reset_async got=%h exp=0", all_outs); end
      @(negedge clk_i); reset_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if ({out_valid_o, busy_o, done_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle%0d got=%b exp=000", i, {out_valid_o, busy_o, done_o});
         end
      end
   endtask

   task automatic test_ordered();
      logic [NE*IW-1:0] v;
      exp_t e, got;
      int n = 0, cyc = 0, busy = 0, dn = 0;
      for (int i = 0; i < NE; i++) v[i*IW +: IW] = 16'(i * 256);
      push_all(v, 8);
      do_capture(v, 8);
      while (n < NE && cyc < 100) begin
         @(negedge clk_i); cyc++;
         capture_i = 1'b0; out_ready_i = 1'b1;
         if (busy_o) busy++;
         if (done_o) dn++;
         if (out_valid_o && out_ready_i) begin
            e   = sb.pop_front();
            got = {out_data_o, out_row_o, out_col_o, out_last_o};
            n_cmp++;
            if (got !== e || out_data_o !== 8'(n)) begin
               n_fail++; $display("FAIL ordered_xfer%0d got=%h exp=%h", n, got, e);
            end
            n++;
         end
      end
      if (n < NE) begin n_cmp++; n_fail++; $display("FAIL ordered_timeout got=%0d exp=%0d", n, NE); sb.delete(); end
      @(negedge clk_i);
      n_cmp++;
      if ({done_o, busy_o, out_valid_o} !== 3'b100) begin
         n_fail++; $display("FAIL ordered_done got=%b exp=100", {done_o, busy_o, out_valid_o});
      end
      @(negedge clk_i);
      n_cmp++;
      if (done_o !== 1'b0 || dn != 0) begin n_fail++; $display("FAIL ordered_done_once got=%b/%0d exp=0/0", done_o, dn); end
      n_cmp++;
      if (busy != NE) begin n_fail++; $display("FAIL ordered_busy_cycles got=%0d exp=%0d", busy, NE); end
   endtask

   task automatic test_round();
      logic [NE*IW-1:0] v;
      logic [7:0] lit[3];
      exp_t e, got;
      int s, nlit;
      for (int k = 0; k < 3; k++) begin
         int n = 0, cyc = 0;
         for (int i = 0; i < NE; i++) v[i*IW +: IW] = 16'($urandom);
         case (k)
            0: begin s = 8;  nlit = 3; v[0 +: 48] = {16'sd32767, -16'sd384, 16'sd384}; lit = '{8'd2, 8'hFF, 8'd127}; end
            1: begin s = 0;  nlit = 3; v[0 +: 48] = {16'sd100, -16'sd32768, 16'sd32767}; lit = '{8'd127, 8'h80, 8'd100}; end
            default: begin s = 15; nlit = 2; v[0 +: 32] = {-16'sd32768, 16'sd32767}; lit = '{8'd1, 8'hFF, 8'd0}; end
         endcase
         push_all(v, s);
         do_capture(v, s);
         while (n < NE && cyc < 100) begin
            @(negedge clk_i); cyc++;
            capture_i = 1'b0; out_ready_i = 1'b1;
            if (out_valid_o && out_ready_i) begin
               e   = sb.pop_front();
               got = {out_data_o, out_row_o, out_col_o, out_last_o};
               n_cmp++;
               if (got !== e) begin n_fail++; $display("FAIL round_s%0d_xfer%0d got=%h exp=%h", s, n, got, e); end
               if (n < nlit) begin
                  n_cmp++;
                  if (out_data_o !== lit[n]) begin
                     n_fail++; $display("FAIL round_s%0d_lit%0d got=%h exp=%h", s, n, out_data_o, lit[n]);
                  end
               end
               n++;
            end
         end
         if (n < NE) begin n_cmp++; n_fail++; $display("FAIL round_timeout got=%0d exp=%0d", n, NE); sb.delete(); end
         repeat (2) @(negedge clk_i);
      end
   endtask

   task automatic test_backpressure();
      logic [NE*IW-1:0] v;
      exp_t e, got;
      int n = 0, cyc = 0, stall = 0, vcyc = 0;
      for (int i = 0; i < NE; i++) v[i*IW +: IW] = 16'($urandom);
      push_all(v, 5);
      do_capture(v, 5);
      while (n < NE && cyc < 100) begin
         @(negedge clk_i); cyc++;
         capture_i   = 1'b0;
         out_ready_i = !(n == 5 && stall < 3);
         if (out_valid_o) vcyc++;
         got = {out_data_o, out_row_o, out_col_o, out_last_o};
         if (out_valid_o && !out_ready_i) begin
            stall++;
            n_cmp++;
            if (got !== sb[0]) begin n_fail++; $display("FAIL bp_hold%0d got=%h exp=%h", stall, got, sb[0]); end
         end else if (out_valid_o) begin
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL bp_xfer%0d got=%h exp=%h", n, got, e); end
            n++;
         end
      end
      if (n < NE) begin n_cmp++; n_fail++; $display("FAIL bp_timeout got=%0d exp=%0d", n, NE); sb.delete(); end
      out_ready_i = 1'b1;
      n_cmp++;
      if (vcyc != NE + 3) begin n_fail++; $display("FAIL bp_valid_cycles got=%0d exp=%0d", vcyc, NE + 3); end
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_ignored_capture();
      logic [NE*IW-1:0] v1, v2;
      exp_t e, got;
      int n = 0, cyc = 0, dn = 0;
      for (int i = 0; i < NE; i++) begin
         v1[i*IW +: IW] = 16'($urandom);
         v2[i*IW +: IW] = 16'($urandom);
      end
      push_all(v1, 6);
      do_capture(v1, 6);
      while (n < NE && cyc < 100) begin
         @(negedge clk_i); cyc++;
         out_ready_i = 1'b1;
         capture_i   = (n == 7 || n == 15);
         if (capture_i) begin results_i = v2; shift_i = 4'd3; end
         if (done_o) dn++;
         if (out_valid_o && out_ready_i) begin
            e   = sb.pop_front();
            got = {out_data_o, out_row_o, out_col_o, out_last_o};
            n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL ign_xfer%0d got=%h exp=%h", n, got, e); end
            n++;
         end
      end
      if (n < NE) begin n_cmp++; n_fail++; $display("FAIL ign_timeout got=%0d exp=%0d", n, NE); sb.delete(); end
      @(negedge clk_i); capture_i = 1'b0;
      n_cmp++;
      if ({done_o, out_valid_o} !== 2'b10 || dn != 0) begin
         n_fail++; $display("FAIL ign_done got=%b/%0d exp=10/0", {done_o, out_valid_o}, dn);
      end
      // The capture seen on the final transfer must not have started a drain.
      @(negedge clk_i);
      n_cmp++;
      if ({done_o, out_valid_o} !== 2'b00) begin n_fail++; $display("FAIL ign_no_requeue got=%b exp=00", {done_o, out_valid_o}); end
      push_all(v2, 4);
      results_i = v2; shift_i = 4'd4; capture_i = 1'b1;
      n = 0; cyc = 0;
      while (n < NE && cyc < 100) begin
         @(negedge clk_i); cyc++;
         capture_i = 1'b0; out_ready_i = 1'b1;
         if (out_valid_o && out_ready_i) begin
            e   = sb.pop_front();
            got = {out_data_o, out_row_o, out_col_o, out_last_o};
            n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL ign_new_xfer%0d got=%h exp=%h", n, got, e); end
            n++;
         end
      end
      if (n < NE) begin n_cmp++; n_fail++; $display("FAIL ign_new_timeout got=%0d exp=%0d", n, NE); sb.delete(); end
      @(negedge clk_i);
      n_cmp++;
      if (done_o !== 1'b1) begin n_fail++; $display("FAIL ign_new_done got=%b exp=1", done_o); end
      @(negedge clk_i);
   endtask

   task automatic test_abort();
      logic [NE*IW-1:0] v, w;
      exp_t e, got;
      int n = 0, cyc = 0;
      for (int i = 0; i < NE; i++) begin
         v[i*IW +: IW] = 16'($urandom);
         w[i*IW +: IW] = 16'($urandom);
      end
      push_all(v, 7);
      do_capture(v, 7);
      while (n < 5 && cyc < 100) begin
         @(negedge clk_i); cyc++;
         capture_i = 1'b0; out_ready_i = 1'b1;
         if (out_valid_o && out_ready_i) begin
            e   = sb.pop_front();
            got = {out_data_o, out_row_o, out_col_o, out_last_o};
            n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL abort_pre_xfer%0d got=%h exp=%h", n, got, e); end
            n++;
         end
      end
      @(posedge clk_i);
      #2 reset_i = 1'b1;
      #1;
      n_cmp++;
      if (all_outs !== '0) begin n_fail++; $display("FAIL abort_outs got=%h exp=0", all_outs); end
      sb.delete();
      @(negedge clk_i); reset_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if ({done_o, out_valid_o} !== 2'b00) begin n_fail++; $display("FAIL abort_quiet%0d got=%b exp=00", i, {done_o, out_valid_o}); end
      end
      push_all(w, 9);
      do_capture(w, 9);
      n = 0; cyc = 0;
      while (n < NE && cyc < 100) begin
         @(negedge clk_i); cyc++;
         capture_i = 1'b0; out_ready_i = 1'b1;
         if (out_valid_o && out_ready_i) begin
            e   = sb.pop_front();
            got = {out_data_o, out_row_o, out_col_o, out_last_o};
            n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL abort_restart_xfer%0d got=%h exp=%h", n, got, e); end
            n++;
         end
      end
      if (n < NE) begin n_cmp++; n_fail++; $display("FAIL abort_timeout got=%0d exp=%0d", n, NE); sb.delete(); end
      @(negedge clk_i);
      n_cmp++;
      if (done_o !== 1'b1) begin n_fail++; $display("FAIL abort_restart_done got=%b exp=1", done_o); end
      @(negedge clk_i);
   endtask

   initial begin
      reset_i     = 1'b1;
      capture_i   = 1'b0;
      out_ready_i = 1'b1;
      results_i   = '0;
      shift_i     = '0;
      test_reset();
      test_ordered();
      test_round();
      test_backpressure();
      test_ignored_capture();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
